dec_trigger_seq: RTL and testbench

DEC_TRIGGER_SEQ -- requirements
Module: dec_trigger_seq

---
 rtl/swerv_types.sv | 15 +
 rtl/rvmaskandmatch.sv | 26 ++
 rtl/dec_trigger_seq.sv | 127 ++++++++++++
 tb/tb_dec_trigger_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swerv_types.sv
// Shared trigger types and defaults for the decode-stage trigger logic.
package swerv_types;

  localparam int unsigned TRIG_NUM_DEFAULT   = 4;
  localparam int unsigned TRIG_CNT_W_DEFAULT = 8;

  typedef struct packed {
    logic        select;   // 1 = data address/value trigger, 0 = instruction address
    logic        match;    // 1 = masked (trailing-ones) compare, 0 = exact
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } trigger_pkt_t;

endpackage

// File: rtl/rvmaskandmatch.sv
// Masked compare: with masken_i set, the run of trailing ones in mask_i is don't-care;
// every other bit must equal data_i exactly.
module rvmaskandmatch #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             masken_i,
  output logic             match_o
);

  logic [WIDTH-1:0] dont_care;
  logic             run;

  always_comb begin
    run       = masken_i;
    dont_care = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run          = run & mask_i[i];
      dont_care[i] = run;
    end
  end

  assign match_o = &(dont_care | ~(mask_i ^ data_i));

endmodule

// File: rtl/dec_trigger_seq.sv
// Decode-stage execute-trigger matcher with per-trigger hit counters and optional
// pairwise chaining (enabled by defining RV_TRIG_CHAIN_EN).
module dec_trigger_seq
  import swerv_types::*;
#(
  parameter int unsigned NUM_TRIG  = TRIG_NUM_DEFAULT,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned CNT_W     = TRIG_CNT_W_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_l,
  input  trigger_pkt_t [NUM_TRIG-1:0]          trigger_pkt_any,
  input  logic [NUM_TRIG-1:0]                  trig_chain,
  input  logic [NUM_TRIG-1:0]                  trig_cnt_wr,
  input  logic [CNT_W-1:0]                     trig_cnt_wdata,
  input  logic [NUM_LANES-1:0][30:0]           dec_pc_d,
  input  logic [NUM_LANES-1:0]                 dec_valid_d,
  input  logic                                 dec_flush,
  output logic [NUM_LANES-1:0][NUM_TRIG-1:0]   dec_trigger_match_e1,
  output logic [NUM_TRIG-1:0][CNT_W-1:0]       trig_cnt
);

  logic [NUM_LANES-1:0][NUM_TRIG-1:0] pc_match, raw_hit, qual_hit, report, match_q;
  logic [NUM_TRIG-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_TRIG-1:0]                any_raw;
  logic                               unused_chain;

  // Odd chain bits (and all of them when chaining is compiled out) carry no meaning.
  assign unused_chain = ^trig_chain;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar t = 0; t < NUM_TRIG; t++) begin : g_trig
      rvmaskandmatch #(
        .WIDTH(32)
      ) u_maskmatch (
        .mask_i  (trigger_pkt_any[t].tdata2),
        .data_i  ({dec_pc_d[l], trigger_pkt_any[t].tdata2[0]}),
        .masken_i(trigger_pkt_any[t].match),
        .match_o (pc_match[l][t])
      );
      assign raw_hit[l][t] = dec_valid_d[l] & trigger_pkt_any[t].execute &
                             trigger_pkt_any[t].m & ~trigger_pkt_any[t].select & pc_match[l][t];
    end
  end

  // A nonzero counter swallows the hit and counts down; only a zero counter lets hits through.
  always_comb begin
    any_raw  = '0;
    cnt_d    = cnt_q;
    qual_hit = '0;
    for (int t = 0; t < NUM_TRIG; t++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        any_raw[t] = any_raw[t] | raw_hit[l][t];
      end
      if (trig_cnt_wr[t]) begin
        cnt_d[t] = trig_cnt_wdata;
      end else if (cnt_q[t] != '0) begin
        if (any_raw[t] && !dec_flush) begin
          cnt_d[t] = cnt_q[t] - CNT_W'(1);
        end
      end else begin
        for (int l = 0; l < NUM_LANES; l++) begin
          qual_hit[l][t] = raw_hit[l][t] & ~dec_flush;
        end
      end
    end
  end

`ifdef RV_TRIG_CHAIN_EN
  logic [NUM_TRIG-1:0] armed_q, armed_d;
  logic                seen, fire, set;

  // Lane order matters: a same-cycle first-half hit only enables strictly higher lanes.
  always_comb begin
    report  = qual_hit;
    armed_d = armed_q;
    seen    = 1'b0;
    fire    = 1'b0;
    set     = 1'b0;
    for (int i = 0; i + 1 < NUM_TRIG; i += 2) begin
      if (trig_chain[i]) begin
        seen = armed_q[i];
        fire = 1'b0;
        set  = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
          report[l][i]   = 1'b0;
          report[l][i+1] = qual_hit[l][i+1] & seen;
          fire           = fire | report[l][i+1];
          seen           = seen | qual_hit[l][i];
          set            = set | qual_hit[l][i];
        end
        if (fire || dec_flush || trig_cnt_wr[i] || trig_cnt_wr[i+1]) begin
          armed_d[i] = 1'b0;
        end else if (set) begin
          armed_d[i] = 1'b1;
        end
      end else begin
        armed_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      armed_q <= '0;
    end else begin
      armed_q <= armed_d;
    end
  end
`else
  assign report = qual_hit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      match_q <= '0;
      cnt_q   <= '0;
    end else begin
      match_q <= report;
      cnt_q   <= cnt_d;
    end
  end

  assign dec_trigger_match_e1 = match_q;
  assign trig_cnt             = cnt_q;

endmodule

// File: tb/tb_dec_trigger_seq.sv
// Scoreboard bench for dec_trigger_seq: directed checks plus randomized traffic.
module tb_dec_trigger_seq;
  import swerv_types::*;

  localparam int unsigned NT = 4;
  localparam int unsigned NL = 2;
  localparam int unsigned CW = 8;

  logic                  clk = 1'b0;
  logic                  rst_l;
  trigger_pkt_t [NT-1:0] tpkt;
  logic [NT-1:0]         chain, cnt_wr;
  logic [CW-1:0]         cnt_wdata;
  logic [NL-1:0][30:0]   pc;
  logic [NL-1:0]         valid;
  logic                  flush;
  logic [NL-1:0][NT-1:0] match_e1;
  logic [NT-1:0][CW-1:0] cnt;

  typedef struct packed {
    logic [NL-1:0][NT-1:0] hits;
    logic [NT-1:0][CW-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int unsigned m_cnt[NT];
  bit          m_armed[NT];

  dec_trigger_seq #(
    .NUM_TRIG (NT),
    .NUM_LANES(NL),
    .CNT_W    (CW)
  ) dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .trigger_pkt_any     (tpkt),
    .trig_chain          (chain),
    .trig_cnt_wr         (cnt_wr),
    .trig_cnt_wdata      (cnt_wdata),
    .dec_pc_d            (pc),
    .dec_valid_d         (valid),
    .dec_flush           (flush),
    .dec_trigger_match_e1(match_e1),
    .trig_cnt            (cnt)
  );

  always #5 clk = ~clk;

  // Address range test: masked mode ignores the trailing ones of tdata2.
  function automatic bit addr_hit(logic [30:0] p, logic [31:0] td, bit masked);
    logic [31:0] a;
    int k;
    a = {p, td[0]};
    k = 0;
    if (masked) while (k < 32 && td[k]) k++;
    if (k == 32) return 1'b1;
    return (a >> k) == (td >> k);
  endfunction

  function automatic exp_t model_eval();
    exp_t        e;
    bit          raw[NL][NT];
    bit          q[NL][NT];
    bit          any_raw[NT];
    int unsigned next_cnt[NT];
    int          first_i;
    bit          fired;
    e = '0;
    if (!rst_l) begin
      for (int t = 0; t < NT; t++) begin
        m_cnt[t]   = 0;
        m_armed[t] = 1'b0;
      end
      return e;
    end
    for (int t = 0; t < NT; t++) begin
      any_raw[t] = 1'b0;
      for (int l = 0; l < NL; l++) begin
        q[l][t]   = 1'b0;
        raw[l][t] = valid[l] && tpkt[t].execute && tpkt[t].m && !tpkt[t].select &&
                    addr_hit(pc[l], tpkt[t].tdata2, tpkt[t].match);
        if (raw[l][t]) any_raw[t] = 1'b1;
      end
    end
    for (int t = 0; t < NT; t++) begin
      if (cnt_wr[t]) begin
        next_cnt[t] = cnt_wdata;
      end else if (m_cnt[t] != 0) begin
        next_cnt[t] = (any_raw[t] && !flush) ? m_cnt[t] - 1 : m_cnt[t];
      end else begin
        next_cnt[t] = 0;
        for (int l = 0; l < NL; l++) q[l][t] = raw[l][t] && !flush;
      end
    end
    for (int t = 0; t < NT; t++)
      for (int l = 0; l < NL; l++) e.hits[l][t] = q[l][t];
`ifdef RV_TRIG_CHAIN_EN
    for (int i = 0; i + 1 < NT; i += 2) begin
      if (chain[i]) begin
        first_i = NL;
        fired   = 1'b0;
        for (int l = NL - 1; l >= 0; l--) if (q[l][i]) first_i = l;
        for (int l = 0; l < NL; l++) begin
          e.hits[l][i]   = 1'b0;
          e.hits[l][i+1] = q[l][i+1] && (m_armed[i] || first_i < l);
          if (e.hits[l][i+1]) fired = 1'b1;
        end
        if (fired || flush || cnt_wr[i] || cnt_wr[i+1]) m_armed[i] = 1'b0;
        else if (first_i < NL) m_armed[i] = 1'b1;
      end else begin
        m_armed[i] = 1'b0;
      end
    end
`else
    first_i = 0;
    fired   = 1'b0;
`endif
    for (int t = 0; t < NT; t++) begin
      m_cnt[t]  = next_cnt[t];
      e.cnt[t]  = CW'(next_cnt[t]);
    end
    return e;
  endfunction

  task automatic step();
    sb.push_back(model_eval());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic idle();
    valid  = '0;
    pc     = '0;
    cnt_wr = '0;
    flush  = 1'b0;
  endtask

  task automatic set_trig(input int t, input logic [31:0] td, input bit masked);
    tpkt[t].select  = 1'b0;
    tpkt[t].match   = masked;
    tpkt[t].execute = 1'b1;
    tpkt[t].m       = 1'b1;
    tpkt[t].tdata2  = td;
  endtask

  task automatic set_lane(input int l, input logic [31:0] addr);
    pc[l]    = addr[31:1];
    valid[l] = 1'b1;
  endtask

  function automatic logic [30:0] pick_pc();
    logic [31:0] pool[8];
    logic [31:0] a;
    pool = '{32'h1000, 32'h1040, 32'h1100, 32'h1800, 32'h2000, 32'h20FE, 32'h3000, 32'h1FFE};
    a = ($urandom_range(0, 9) == 0) ? $urandom : pool[$urandom_range(0, 7)];
    return a[31:1];
  endfunction

  // Monitor: every cycle the DUT presents a registered result for the previous cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (match_e1 !== e.hits) begin
          n_fail++;
          $display("FAIL sb_match cycle %0d: got %h expected %h", cyc, match_e1, e.hits);
        end
        n_tests++;
        if (cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL sb_cnt cycle %0d: got %h expected %h", cyc, cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tpool[8];
    tpool = '{32'h1000, 32'h10FF, 32'h1800, 32'h2000, 32'h1FFF, 32'h3000, 32'h20FF,
              32'hFFFF_FFFF};
    idle();
    rst_l     = 1'b0;
    chain     = '0;
    cnt_wdata = '0;
    tpkt      = '0;
    step();
    step();
    chk("reset_match", 32'(match_e1), 32'h0);
    chk("reset_cnt", 32'(cnt), 32'h0);

    rst_l = 1'b1;
    set_trig(0, 32'h1000, 1'b0);
    set_trig(1, 32'h10FF, 1'b1);
    set_trig(2, 32'h2000, 1'b0);
    set_trig(3, 32'h3000, 1'b0);

    idle(); set_lane(0, 32'h1000); step();
    chk("t0_exact_hit", 32'(match_e1[0][0]), 32'h1);
    idle(); step();
    chk("t0_exact_once", 32'(match_e1[0][0]), 32'h0);

    idle(); set_lane(1, 32'h1040); step();
    chk("t1_masked_hit", 32'(match_e1[1][1]), 32'h1);
    idle(); set_lane(1, 32'h1100); step();
    chk("t1_masked_miss", 32'(match_e1[1][1]), 32'h0);

    idle(); cnt_wr[2] = 1'b1; cnt_wdata = 8'd2; step();
    chk("cnt_load", 32'(cnt[2]), 32'h2);
    for (int k = 0; k < 3; k++) begin
      idle(); set_lane(0, 32'h2000); step();
      chk("cnt_hit_value", 32'(cnt[2]), (k == 0) ? 32'h1 : 32'h0);
      chk("cnt_hit_report", 32'(match_e1[0][2]), (k == 2) ? 32'h1 : 32'h0);
    end
    idle(); step();

`ifdef RV_TRIG_CHAIN_EN
    set_trig(1, 32'h1800, 1'b0);
    chain[0] = 1'b1;
    idle(); step();
    idle(); set_lane(0, 32'h1000); step();
    chk("chain_t0_hidden", 32'(match_e1), 32'h0);
    idle(); step(); step();
    set_lane(0, 32'h1800); step();
    chk("chain_t1_armed", 32'(match_e1), 32'h02);
    idle(); set_lane(0, 32'h1800); step();
    chk("chain_t1_alone", 32'(match_e1), 32'h0);

    idle(); set_lane(0, 32'h1000); set_lane(1, 32'h1800); step();
    chk("chain_same_cycle", 32'(match_e1), 32'h20);
    idle(); set_lane(0, 32'h1800); set_lane(1, 32'h1000); step();
    chk("chain_reversed", 32'(match_e1), 32'h0);
    idle(); set_lane(0, 32'h1800); step();
    chk("chain_reversed_armed", 32'(match_e1), 32'h02);

    idle(); set_lane(0, 32'h1000); step();
    idle(); flush = 1'b1; step();
    idle(); set_lane(0, 32'h1800); step();
    chk("chain_flush_disarm", 32'(match_e1), 32'h0);
`endif

    idle(); flush = 1'b1; set_lane(0, 32'h3000); step();
    chk("flush_hit_zero", 32'(match_e1), 32'h0);
    idle(); set_lane(0, 32'h3000); step();
    chk("no_flush_hit", 32'(match_e1[0][3]), 32'h1);
    chain = '0;

    for (int c = 0; c < 800; c++) begin
      if (c % 40 == 0) begin
        for (int t = 0; t < NT; t++) begin
          tpkt[t].tdata2  = tpool[$urandom_range(0, 7)];
          tpkt[t].match   = 1'($urandom_range(0, 1));
          tpkt[t].execute = ($urandom_range(0, 7) != 0);
          tpkt[t].m       = ($urandom_range(0, 7) != 0);
          tpkt[t].select  = ($urandom_range(0, 7) == 0);
        end
      end
      for (int l = 0; l < NL; l++) begin
        valid[l] = ($urandom_range(0, 3) != 0);
        pc[l]    = pick_pc();
      end
      for (int t = 0; t < NT; t++) cnt_wr[t] = ($urandom_range(0, 15) == 0);
      cnt_wdata = CW'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 15) == 0);
      chain     = NT'($urandom);
      rst_l     = ($urandom_range(0, 99) != 0);
      step();
    end

    idle();
    rst_l = 1'b1;
    step();
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
